// File: rtl/svpwm_pkg.sv
// Shared types and elaboration-time constants for the space-vector modulator.
package svpwm_pkg;

    typedef enum logic [1:0] {
        MODE_SPWM     = 2'd0,
        MODE_SVPWM    = 2'd1,
        MODE_DPWM_MIN = 2'd2
    } mode_e;

    // round(sqrt(3)/2 * 2^coef_frac) = round(sqrt(3 * 2^(2*coef_frac-2))), integer-only
    function automatic int unsigned sqrt3_by_2(input int unsigned coef_frac);
        logic [63:0] target;
        logic [63:0] r;
        logic [63:0] cand;
        target = 64'd3 << (2 * coef_frac - 2);
        r      = '0;
        for (int b = 31; b >= 0; b--) begin
            cand = r | (64'd1 << b);
            if (cand * cand <= target) r = cand;
        end
        // (r + 0.5)^2 = r^2 + r + 0.25, so round up when target exceeds r^2 + r
        if (r * r + r < target) r = r + 64'd1;
        return r[31:0];
    endfunction

    function automatic int sat_max(input int unsigned data_width);
        return (32'sd1 <<< (data_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int unsigned data_width);
        return -(32'sd1 <<< (data_width - 1));
    endfunction

endpackage

// File: rtl/svpwm_if.sv
// AXI-Stream style input/output bundle of the modulator.
interface svpwm_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PWM_WIDTH  = 16
);
    logic [2*DATA_WIDTH-1:0] s_axis_tdata;
    logic [1:0]              s_axis_tuser;
    logic                    s_axis_tvalid;
    logic                    s_axis_tready;
    logic [3*PWM_WIDTH-1:0]  m_axis_tdata;
    logic                    m_axis_tuser;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;

    // Environment side: drives the input stream and the output ready
    modport master (
        output s_axis_tdata, s_axis_tuser, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
    );

    // Modulator side
    modport slave (
        input  s_axis_tdata, s_axis_tuser, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tuser, m_axis_tvalid
    );
endinterface

// File: rtl/svpwm_minmax3.sv
// Registered maximum and minimum of three signed values.
module svpwm_minmax3 #(
    parameter int unsigned WIDTH = 18
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] c,
    output logic signed [WIDTH-1:0] vmax,
    output logic signed [WIDTH-1:0] vmin
);
    logic signed [WIDTH-1:0] max_d, min_d;

    // Combinational three-way compare
    always_comb begin
        max_d = a;
        min_d = a;
        if (b > max_d) max_d = b;
        if (c > max_d) max_d = c;
        if (b < min_d) min_d = b;
        if (c < min_d) min_d = c;
    end

    // Result register, held while the pipeline is stalled
    always_ff @(posedge clk) begin
        if (en) begin
            vmax <= max_d;
            vmin <= min_d;
        end
    end
endmodule

// File: rtl/svpwm_modulator.sv
// Five-stage space-vector modulator: (alpha, beta) -> three unsigned phase duties.
module svpwm_modulator
    import svpwm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PWM_WIDTH  = 16,
    parameter int unsigned COEF_FRAC  = 15
) (
    input  logic   clk,
    input  logic   rstn,
    svpwm_if.slave bus
);
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned IW = DW + 2;          // phase voltages
    localparam int unsigned SW = DW + 3;          // phase + common-mode sums
    localparam int unsigned KW = COEF_FRAC + 2;   // K is positive, one sign bit
    localparam int unsigned PW = DW + KW;
    localparam logic signed [KW-1:0] K    = KW'(sqrt3_by_2(COEF_FRAC));
    localparam logic signed [SW-1:0] SMAX = SW'(sat_max(DW));
    localparam logic signed [SW-1:0] SMIN = SW'(sat_min(DW));

    logic                   ce;
    logic [3:0]             vld_q;
    logic                   m_tvalid_q;
    logic [3*PWM_WIDTH-1:0] m_tdata_q;
    logic                   m_tuser_q;

    logic signed [DW-1:0]   alpha_in, beta_in, alpha_q1;
    logic signed [PW-1:0]   prod_d, prod_q1;
    logic [1:0]             mode_q1, mode_q2, mode_q3;
    logic signed [IW-1:0]   bk, ah;
    logic signed [IW-1:0]   v_d2 [3];
    logic signed [IW-1:0]   v_q2 [3];
    logic signed [IW-1:0]   v_q3 [3];
    logic signed [IW-1:0]   vmax_q3, vmin_q3;
    logic signed [SW-1:0]   mm_sum, vcom;
    logic signed [SW-1:0]   s_d4 [3];
    logic signed [SW-1:0]   s_q4 [3];
    logic [DW-1:0]          biased [3];
    logic [2:0]             clip;
    logic [3*PWM_WIDTH-1:0] duty_d;

    assign ce                = !m_tvalid_q || bus.m_axis_tready;
    assign bus.s_axis_tready = ce && rstn;
    assign bus.m_axis_tvalid = m_tvalid_q;
    assign bus.m_axis_tdata  = m_tdata_q;
    assign bus.m_axis_tuser  = m_tuser_q;

    assign alpha_in = bus.s_axis_tdata[2*DW-1:DW];
    assign beta_in  = bus.s_axis_tdata[DW-1:0];
    assign prod_d   = PW'(beta_in) * PW'(K);

    // Stage 2: inverse Clarke from the registered product
    always_comb begin
        bk      = IW'(prod_q1 >>> COEF_FRAC);
        ah      = IW'(alpha_q1) >>> 1;
        v_d2[0] = IW'(alpha_q1);
        v_d2[1] = bk - ah;
        v_d2[2] = -ah - bk;
    end

    // Stage 3: max/min of the three phase voltages
    svpwm_minmax3 #(
        .WIDTH (IW)
    ) u_minmax (
        .clk  (clk),
        .en   (ce),
        .a    (v_q2[0]),
        .b    (v_q2[1]),
        .c    (v_q2[2]),
        .vmax (vmax_q3),
        .vmin (vmin_q3)
    );

    // Stage 4: common-mode offset selected by the beat's own mode; code 3 behaves as SVPWM
    always_comb begin
        mm_sum = SW'(vmax_q3) + SW'(vmin_q3);
        vcom   = '0;
        case (mode_q3)
            MODE_SPWM:     vcom = '0;
            MODE_DPWM_MIN: vcom = SMIN - SW'(vmin_q3);
            default:       vcom = -(mm_sum >>> 1);
        endcase
        for (int i = 0; i < 3; i++) s_d4[i] = SW'(v_q3[i]) + vcom;
    end

    // Stage 5: clamp, bias to unsigned (flip of the sign bit) and keep the top PWM bits
    always_comb begin
        clip   = '0;
        duty_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (s_q4[i] > SMAX) begin
                clip[i]   = 1'b1;
                biased[i] = '1;
            end else if (s_q4[i] < SMIN) begin
                clip[i]   = 1'b1;
                biased[i] = '0;
            end else begin
                biased[i] = {~s_q4[i][DW-1], s_q4[i][DW-2:0]};
            end
            duty_d[(2-i)*PWM_WIDTH +: PWM_WIDTH] = biased[i][DW-1 -: PWM_WIDTH];
        end
    end

    // Valid bits of stages 1..4; cleared by reset so in-flight samples vanish
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
        end else if (ce) begin
            vld_q <= {vld_q[2:0], bus.s_axis_tvalid};
        end
    end

    // Datapath registers of stages 1..4 advance together under the global enable
    always_ff @(posedge clk) begin
        if (ce) begin
            alpha_q1 <= alpha_in;
            prod_q1  <= prod_d;
            mode_q1  <= bus.s_axis_tuser;
            v_q2     <= v_d2;
            mode_q2  <= mode_q1;
            v_q3     <= v_q2;
            mode_q3  <= mode_q2;
            s_q4     <= s_d4;
        end
    end

    // Output register; data only changes when a real sample lands
    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_tvalid_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tuser_q  <= 1'b0;
        end else if (ce) begin
            m_tvalid_q <= vld_q[3];
            if (vld_q[3]) begin
                m_tdata_q <= duty_d;
                m_tuser_q <= |clip;
            end
        end
    end
endmodule

// File: tb/tb_svpwm_modulator.sv
// Directed bench for svpwm_modulator with hand-computed duty vectors.
module tb_svpwm_modulator;
    import svpwm_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    svpwm_if #(.DATA_WIDTH(16), .PWM_WIDTH(16)) bus ();

    svpwm_modulator #(
        .DATA_WIDTH (16),
        .PWM_WIDTH  (16),
        .COEF_FRAC  (15)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [48:0] got_q [$];
    logic [48:0] exp_q [$];
    logic [33:0] stim_q [$];
    logic        held_vld = 1'b0;
    logic [48:0] held;
    logic        acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe at the negedge, then return 1 time unit after the next posedge
    task automatic clk_step();
        @(negedge clk);
        check("s_tready", 64'(bus.s_axis_tready),
              64'(rstn && !(bus.m_axis_tvalid && !bus.m_axis_tready)));
        if (held_vld)
            check("stall_hold", {bus.m_axis_tvalid, bus.m_axis_tuser, bus.m_axis_tdata},
                  {1'b1, held});
        held_vld = rstn && bus.m_axis_tvalid && !bus.m_axis_tready;
        held     = {bus.m_axis_tuser, bus.m_axis_tdata};
        if (rstn && bus.m_axis_tvalid && bus.m_axis_tready)
            got_q.push_back({bus.m_axis_tuser, bus.m_axis_tdata});
        acc = rstn && bus.s_axis_tvalid && bus.s_axis_tready;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int a, input int b, input int m,
                       input int u, input int v, input int w, input bit sat);
        stim_q.push_back({2'(m), 16'(a), 16'(b)});
        exp_q.push_back({sat, 16'(u), 16'(v), 16'(w)});
    endtask

    // Send the queued beats back-to-back and compare the emerging beats in order
    task automatic run_stream(input string name, input bit bp);
        int n    = stim_q.size();
        int sent = 0;
        int base = got_q.size();
        int c    = 0;
        while ((sent < n || got_q.size() < base + n) && c < 200) begin
            c++;
            if (sent < n) begin
                {bus.s_axis_tuser, bus.s_axis_tdata} = stim_q[sent];
                bus.s_axis_tvalid = 1'b1;
            end else begin
                bus.s_axis_tvalid = 1'b0;
            end
            if (bp) bus.m_axis_tready = (c >= 6 && c <= 9) ? 1'b0 :
                                        (c > 9) ? 1'($urandom_range(0, 1)) : 1'b1;
            else    bus.m_axis_tready = 1'b1;
            clk_step();
            if (acc) sent++;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        check({name, "_count"}, 64'(got_q.size() - base), 64'(n));
        for (int i = 0; i < n; i++)
            if (base + i < got_q.size())
                check($sformatf("%s_beat%0d", name, i), 64'(got_q[base+i]), 64'(exp_q[i]));
        stim_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int n;
        int base;
        rstn              = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        @(posedge clk);
        #1;
        clk_step();
        clk_step();
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(bus.m_axis_tdata), 64'd0);
        check("rst_tuser", 64'(bus.m_axis_tuser), 64'd0);
        rstn = 1'b1;

        // Zero input, rotating-phase and saturating vectors in every mode
        add(0, 0, 0, 32768, 32768, 32768, 0);
        add(0, 0, 1, 32768, 32768, 32768, 0);
        add(0, 0, 2, 0, 0, 0, 0);
        add(16384, 0, 0, 49152, 24576, 24576, 0);
        add(16384, 0, 1, 45056, 20480, 20480, 0);
        add(16384, 0, 2, 24576, 0, 0, 0);
        add(-32768, 32767, 0, 0, 65535, 20775, 1);
        add(-32768, 32767, 1, 0, 65535, 14779, 1);
        add(0, 16384, 1, 32768, 46957, 18579, 0);
        add(0, 16384, 2, 14189, 28378, 0, 0);
        add(-1, 0, 0, 32767, 32769, 32769, 0);
        add(0, 0, 3, 32768, 32768, 32768, 0);
        run_stream("vec", 1'b0);

        // Backpressure: stall on cycles 6..9, random ready afterwards
        add(16384, 0, 0, 49152, 24576, 24576, 0);
        add(16384, 0, 1, 45056, 20480, 20480, 0);
        add(16384, 0, 2, 24576, 0, 0, 0);
        add(-32768, 32767, 0, 0, 65535, 20775, 1);
        add(0, 16384, 1, 32768, 46957, 18579, 0);
        add(0, 16384, 2, 14189, 28378, 0, 0);
        add(-1, 0, 0, 32767, 32769, 32769, 0);
        add(0, 0, 2, 0, 0, 0, 0);
        run_stream("bp", 1'b1);

        // Mode alternating on consecutive beats of the same reference
        for (int i = 0; i < 2; i++) begin
            add(16384, 0, 0, 49152, 24576, 24576, 0);
            add(16384, 0, 1, 45056, 20480, 20480, 0);
            add(16384, 0, 2, 24576, 0, 0, 0);
        end
        run_stream("mode", 1'b0);

        // Reset with three samples in flight
        for (int i = 0; i < 3; i++) begin
            bus.s_axis_tdata  = {16'd16384, 16'd0};
            bus.s_axis_tuser  = 2'd0;
            bus.s_axis_tvalid = 1'b1;
            clk_step();
        end
        bus.s_axis_tvalid = 1'b0;
        rstn = 1'b0;
        clk_step();
        rstn = 1'b1;
        check("rst2_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst2_tdata", 64'(bus.m_axis_tdata), 64'd0);
        check("rst2_tuser", 64'(bus.m_axis_tuser), 64'd0);
        base = got_q.size();
        repeat (8) clk_step();
        check("rst2_no_beats", 64'(got_q.size() - base), 64'd0);
        check("rst2_tdata_idle", 64'(bus.m_axis_tdata), 64'd0);

        // Single beat latency after reset
        bus.s_axis_tdata  = {16'd16384, 16'd0};
        bus.s_axis_tuser  = 2'd1;
        bus.s_axis_tvalid = 1'b1;
        clk_step();
        check("lat_accept", 64'(acc), 64'd1);
        bus.s_axis_tvalid = 1'b0;
        n = 1;
        while (!bus.m_axis_tvalid && n < 20) begin
            clk_step();
            n++;
        end
        check("latency", 64'(n), 64'd5);
        base = got_q.size();
        clk_step();
        check("lat_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base)
            check("lat_beat", 64'(got_q[base]), 64'({1'b0, 16'd45056, 16'd20480, 16'd20480}));
        clk_step();
        check("lat_drained", 64'(bus.m_axis_tvalid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/svpwm_modulator.md
# svpwm_modulator

Parametrised space-vector modulator for the FOC datapath. It converts an (alpha, beta) voltage reference into three unsigned phase duty cycles, selectable per sample between sinusoidal, min-max-injection SVPWM and discontinuous (DPWM-min) modulation. It adds clamping with a saturation flag and full AXI-Stream backpressure. It sits between the inverse Park transform and the PWM timer.

## Interface
Parameters:
- DATA_WIDTH, 16: width of alpha and beta, signed Q1.(DATA_WIDTH-1); ±1.0 is full scale.
- PWM_WIDTH, 16: width of each output duty, unsigned; must be ≤ DATA_WIDTH.
- COEF_FRAC, 15: fractional bits of the √3/2 constant (28378 at 15).

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- s_axis_tdata  in  2*DATA_WIDTH  {alpha, beta}; alpha in the MSBs
- s_axis_tuser  in  2  mode: 0 = SPWM, 1 = SVPWM, 2 = DPWM-min, 3 = treated as SVPWM
- s_axis_tvalid  in  1  input beat valid
- s_axis_tready  out  1  input accepted when high with tvalid
- m_axis_tdata  out  3*PWM_WIDTH  {u, v, w}; u in the MSBs
- m_axis_tuser  out  1  saturation: any phase was clamped
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready

## Operation
- Clarke inverse, per beat:
  - va = alpha
  - vb = -(alpha>>>1) + ((beta·K)>>>COEF_FRAC)
  - vc = -(alpha>>>1) - ((beta·K)>>>COEF_FRAC)
  - K = round(√3/2 · 2^COEF_FRAC).
  - All shifts are arithmetic (floor).
  - Internal width is DATA_WIDTH+2 signed. No intermediate overflow is allowed.
- Common-mode offset vcom, chosen by the mode captured with the same beat:
  - SPWM: vcom = 0.
  - SVPWM: vcom = -((vmax+vmin)>>>1).
  - DPWM-min: vcom = -2^(DATA_WIDTH-1) - vmin. The lowest phase is driven to duty 0.
- Per phase x:
  - s = va/vb/vc + vcom.
  - Clamp s to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - duty = (s + 2^(DATA_WIDTH-1)) as unsigned, then its top PWM_WIDTH bits.
- m_axis_tuser = OR of the three clamp events for that sample.
- Mode is sampled per beat. A mode change takes effect on exactly the next accepted beat. There is no mixing within a sample.

## Timing
- Pipeline of 5 stages:
  1. product and input register
  2. va, vb, vc
  3. max/min
  4. vcom and sums
  5. clamp and output register
- Latency is 5 clk from input acceptance to m_axis_tvalid, with no stall.
- Throughput is 1 sample/clk.
- Global clock enable: ce = !m_axis_tvalid || m_axis_tready. All stages, including the valid bits, advance only when ce = 1.
- s_axis_tready = ce && rstn, which is combinational. An empty pipeline never deasserts it.
- Output stability: while m_axis_tvalid = 1 and m_axis_tready = 0, m_axis_tdata and m_axis_tuser hold stable.
- Bubbles: valid bits propagate through the pipeline. Invalid slots never produce output beats. Stalls never drop, duplicate or reorder samples.
- Reset:
  - Values: m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tuser = 0; all valid bits are cleared.
  - Mid-stream reset discards all in-flight samples.
  - The first beat is accepted on the first clk with rstn = 1.

## Structure
- Package svpwm_pkg:
  - mode enumeration: MODE_SPWM = 0, MODE_SVPWM = 1, MODE_DPWM_MIN = 2
  - function sqrt3_by_2(COEF_FRAC) returning K
  - saturation limits as functions of DATA_WIDTH
- Sub-module svpwm_minmax3: registered max and min of three signed values, with width parameter.
- Everything else stays in the top module.

## Test plan
All scenarios use DATA_WIDTH = 16, PWM_WIDTH = 16, COEF_FRAC = 15.
1. alpha = 0, beta = 0, each mode:
   - SPWM and SVPWM: u = v = w = 32768.
   - DPWM-min: 0, 0, 0.
   - Saturation flag 0 in all modes.
2. alpha = 16384, beta = 0:
   - SPWM → 49152, 24576, 24576.
   - SVPWM → 45056, 20480, 20480.
   - DPWM-min → 24576, 0, 0.
   - Saturation flag 0.
3. SPWM, alpha = -32768, beta = 32767 → u = 0, v = 65535 (clamped), w = 20775, saturation flag = 1.
4. Backpressure:
   - Stimulus: 8 back-to-back beats; m_axis_tready held low on cycles 6–9, then random.
   - Required: all 8 outputs arrive in order, and output data is stable while stalled.
   - Required: s_axis_tready is low exactly while the output is stalled and valid.
5. Mode switching: alternate mode 0/1/2 on consecutive beats of the same alpha/beta → each output matches its own beat's mode.
6. Reset: assert rstn low for 1 clk with 3 beats in flight → no output beats emerge, outputs are 0, and the next beat returns with 5-clk latency.
